controle_estoque: RTL and testbench
===================================

CONTROLE_ESTOQUE -- requirements
Module: controle_estoque

Interface
REQ-001 The block SHALL have parameter CAPACIDADE, default 20: cork magazine capacity, range 1..63.
REQ-002 The block SHALL have parameter LIMIAR, default 5: refill request threshold, less than CAPACIDADE.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000: clk cycles in SOLICITA before alarm, range 1..65535.
REQ-004 The block SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 The block SHALL have port Reset, input, 1: synchronous, active-low reset.
REQ-006 The block SHALL have port Dec_Rolha, input, 1: one cork consumed by the sealing actuator.
REQ-007 The block SHALL have port Inc_Duzia, input, 1: one bottle sealed and counted.
REQ-008 The block SHALL have port Ack_Reposicao, input, 1: magazine refilled by the operator or feeder.
REQ-009 The block SHALL have port Rolha_Disponivel, output, 1: stock is nonzero.
REQ-010 The block SHALL have port Estoque, output, 6: current cork count.
REQ-011 The block SHALL have port Req_Reposicao, output, 1: refill request.
REQ-012 The block SHALL have port Alarme_Reposicao, output, 1: refill overdue.
REQ-013 The block SHALL have port Garrafas, output, 4: bottles in the current dozen, 0..11.
REQ-014 The block SHALL have port Duzias, output, 7: completed dozens, 0..99.
REQ-015 The block SHALL have port Pulso_Duzia, output, 1: one-cycle pulse on dozen completion.
REQ-016 The block SHALL have port Erro_Subfluxo, output, 1: sticky flag for consumption at zero stock.

Function
REQ-017 The block SHALL rising-edge-detect Dec_Rolha, Inc_Duzia and Ack_Reposicao with registered previous values; a held-high input counts once.
REQ-018 On a Dec_Rolha edge with Estoque>0 and no load in the same cycle, the block SHALL set Estoque to Estoque-1 on the next edge.
REQ-019 On a Dec_Rolha edge with Estoque==0, the block SHALL hold Estoque at 0 and set Erro_Subfluxo until reset.
REQ-020 Rolha_Disponivel SHALL be combinational (Estoque!=0), with no added latency.
REQ-021 The refill FSM SHALL have states NORMAL, SOLICITA and CARGA.
REQ-022 In NORMAL, when Estoque<=LIMIAR the FSM SHALL go to SOLICITA; otherwise it SHALL stay in NORMAL.
REQ-023 In SOLICITA, Req_Reposicao SHALL be 1 (Moore output) and a 16-bit timer SHALL count each cycle.
REQ-024 In SOLICITA, a timer value of TIMEOUT-1 SHALL set Alarme_Reposicao and the timer SHALL saturate.
REQ-025 In SOLICITA, an Ack_Reposicao edge SHALL load Estoque=CAPACIDADE (or CAPACIDADE-1 if a Dec_Rolha edge occurs in the same cycle), clear the timer and Alarme_Reposicao, and move the FSM to CARGA.
REQ-026 In CARGA, Req_Reposicao SHALL be 0, and the FSM SHALL go to NORMAL once Ack_Reposicao is low.
REQ-027 In CARGA, a Dec_Rolha edge SHALL decrement Estoque normally.
REQ-028 Ack_Reposicao edges outside SOLICITA SHALL be ignored.
REQ-029 An undefined state code SHALL recover to NORMAL.
REQ-030 On an Inc_Duzia edge with Garrafas<11, the block SHALL increment Garrafas.
REQ-031 On an Inc_Duzia edge with Garrafas==11, the block SHALL set Garrafas to 0, increment Duzias (wrapping 99 to 0), and assert Pulso_Duzia for exactly the next cycle.
REQ-032 Dec_Rolha and Inc_Duzia edges in the same cycle SHALL both take effect.

Reset
REQ-033 While Reset==0 at a rising clk edge, the block SHALL set Estoque=CAPACIDADE, FSM=NORMAL, timer=0, Garrafas=0 and Duzias=0.
REQ-034 While Reset==0 at a rising clk edge, the block SHALL set Req_Reposicao, Alarme_Reposicao, Pulso_Duzia and Erro_Subfluxo to 0, and the edge registers to 0.
REQ-035 Reset applied in SOLICITA or CARGA SHALL abort the handshake with no load, taking effect at the same edge.

Verification
REQ-036 Reset, then 15 Dec_Rolha pulses -> Estoque=5, Req_Reposicao=1 at the cycle after Estoque reaches 5, Rolha_Disponivel=1.
REQ-037 From Estoque=5, hold Ack_Reposicao high for 4 cycles, then drop it -> Estoque=20 once, FSM in CARGA until Ack low, then NORMAL; a second Ack pulse in NORMAL has no effect.
REQ-038 From Estoque=1 with no Ack: 2 Dec_Rolha pulses -> Estoque=0, Rolha_Disponivel=0, Erro_Subfluxo=1; after TIMEOUT cycles in SOLICITA, Alarme_Reposicao=1.
REQ-039 Dec_Rolha edge in the same cycle as an Ack edge in SOLICITA -> Estoque=19.
REQ-040 12 Inc_Duzia pulses -> Garrafas 0..11 then 0, Duzias=1, one single-cycle Pulso_Duzia; preload Duzias=99 via 1188 pulses -> next dozen gives Duzias=0.
REQ-041 Reset=0 for one edge mid-SOLICITA with Garrafas=7 -> all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/controle_estoque.sv
// Cork magazine stock control for a bottle-sealing line: stock count, refill
// handshake FSM with overdue alarm, and bottle/dozen counters.
module controle_estoque #(
  parameter int CAPACIDADE = 20,
  parameter int LIMIAR     = 5,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Dec_Rolha,
  input  logic       Inc_Duzia,
  input  logic       Ack_Reposicao,
  output logic       Rolha_Disponivel,
  output logic [5:0] Estoque,
  output logic       Req_Reposicao,
  output logic       Alarme_Reposicao,
  output logic [3:0] Garrafas,
  output logic [6:0] Duzias,
  output logic       Pulso_Duzia,
  output logic       Erro_Subfluxo
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SOLICITA = 2'd1,
    CARGA    = 2'd2
  } estado_t;

  localparam logic [5:0]  CAP     = 6'(CAPACIDADE);
  localparam logic [5:0]  LIM     = 6'(LIMIAR);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  estado_t     estado_q, estado_d;
  logic [5:0]  estoque_q, estoque_d;
  logic [15:0] timer_q, timer_d;
  logic        alarme_q, alarme_d;
  logic        erro_q, erro_d;
  logic [3:0]  garrafas_q, garrafas_d;
  logic [6:0]  duzias_q, duzias_d;
  logic        pulso_q, pulso_d;
  logic        dec_prev_q, inc_prev_q, ack_prev_q;
  logic        dec_edge, inc_edge, ack_edge;

  assign dec_edge = Dec_Rolha & ~dec_prev_q;
  assign inc_edge = Inc_Duzia & ~inc_prev_q;
  assign ack_edge = Ack_Reposicao & ~ack_prev_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    estado_d  = estado_q;
    estoque_d = estoque_q;
    timer_d   = timer_q;
    alarme_d  = alarme_q;
    erro_d    = erro_q;

    if (dec_edge) begin
      if (estoque_q != '0) estoque_d = estoque_q - 6'd1;
      else                 erro_d    = 1'b1;
    end

    case (estado_q)
      NORMAL: begin
        timer_d = '0;
        if (estoque_q <= LIM) estado_d = SOLICITA;
      end
      SOLICITA: begin
        if (ack_edge) begin
          // The load absorbs a simultaneous consumption, so it can never underflow.
          estoque_d = dec_edge ? CAP - 6'd1 : CAP;
          erro_d    = erro_q;
          timer_d   = '0;
          alarme_d  = 1'b0;
          estado_d  = CARGA;
        end else if (timer_q == TO_LAST) begin
          alarme_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      CARGA: begin
        if (!Ack_Reposicao) estado_d = NORMAL;
      end
      default: estado_d = NORMAL;
    endcase
  end

  always_comb begin
    garrafas_d = garrafas_q;
    duzias_d   = duzias_q;
    pulso_d    = 1'b0;
    if (inc_edge) begin
      if (garrafas_q == 4'd11) begin
        garrafas_d = '0;
        duzias_d   = (duzias_q == 7'd99) ? 7'd0 : duzias_q + 7'd1;
        pulso_d    = 1'b1;
      end else begin
        garrafas_d = garrafas_q + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      estado_q   <= NORMAL;
      estoque_q  <= CAP;
      timer_q    <= '0;
      alarme_q   <= 1'b0;
      erro_q     <= 1'b0;
      garrafas_q <= '0;
      duzias_q   <= '0;
      pulso_q    <= 1'b0;
      dec_prev_q <= 1'b0;
      inc_prev_q <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      estoque_q  <= estoque_d;
      timer_q    <= timer_d;
      alarme_q   <= alarme_d;
      erro_q     <= erro_d;
      garrafas_q <= garrafas_d;
      duzias_q   <= duzias_d;
      pulso_q    <= pulso_d;
      dec_prev_q <= Dec_Rolha;
      inc_prev_q <= Inc_Duzia;
      ack_prev_q <= Ack_Reposicao;
    end
  end

  assign Rolha_Disponivel = (estoque_q != '0);
  assign Estoque          = estoque_q;
  assign Req_Reposicao    = (estado_q == SOLICITA);
  assign Alarme_Reposicao = alarme_q;
  assign Garrafas         = garrafas_q;
  assign Duzias           = duzias_q;
  assign Pulso_Duzia      = pulso_q;
  assign Erro_Subfluxo    = erro_q;

endmodule

// File: tb/tb_controle_estoque.sv
// Self-checking bench for controle_estoque: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_controle_estoque;

  localparam int CAP     = 20;
  localparam int LIM     = 5;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Dec_Rolha = 1'b0, Inc_Duzia = 1'b0, Ack_Reposicao = 1'b0;
  logic       Rolha_Disponivel, Req_Reposicao, Alarme_Reposicao, Pulso_Duzia, Erro_Subfluxo;
  logic [5:0] Estoque;
  logic [3:0] Garrafas;
  logic [6:0] Duzias;

  int n_checks = 0;
  int n_pass   = 0;

  controle_estoque #(.CAPACIDADE(CAP), .LIMIAR(LIM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset), .Dec_Rolha(Dec_Rolha), .Inc_Duzia(Inc_Duzia),
    .Ack_Reposicao(Ack_Reposicao), .Rolha_Disponivel(Rolha_Disponivel),
    .Estoque(Estoque), .Req_Reposicao(Req_Reposicao), .Alarme_Reposicao(Alarme_Reposicao),
    .Garrafas(Garrafas), .Duzias(Duzias), .Pulso_Duzia(Pulso_Duzia),
    .Erro_Subfluxo(Erro_Subfluxo)
  );

  always #5 clk = ~clk;

  // Behavioural model: stock and counters as plain integers, handshake as flags.
  int m_stock, m_wait_cycles, m_bottles, m_dozens;
  bit m_wait, m_load, m_alarm, m_pulse, m_err;
  bit p_dec, p_inc, p_ack;

  task automatic model_step(input bit d, input bit i, input bit a, input bit r);
    bit de, ie, ae, go_wait;
    if (!r) begin
      m_stock = CAP; m_wait = 0; m_load = 0; m_wait_cycles = 0; m_alarm = 0;
      m_bottles = 0; m_dozens = 0; m_pulse = 0; m_err = 0;
      p_dec = 0; p_inc = 0; p_ack = 0;
      return;
    end
    de = d && !p_dec; ie = i && !p_inc; ae = a && !p_ack;
    p_dec = d; p_inc = i; p_ack = a;
    m_pulse = 0;
    if (ie) begin
      if (m_bottles == 11) begin
        m_bottles = 0; m_dozens = (m_dozens + 1) % 100; m_pulse = 1;
      end else m_bottles++;
    end
    if (m_wait && ae) begin
      m_stock = de ? CAP - 1 : CAP;
      m_wait = 0; m_load = 1; m_wait_cycles = 0; m_alarm = 0;
    end else begin
      go_wait = !m_wait && !m_load && (m_stock <= LIM);
      if (m_wait) begin
        if (m_wait_cycles == TIMEOUT - 1) m_alarm = 1;
        else m_wait_cycles++;
      end else if (m_load) begin
        if (!a) m_load = 0;
      end else if (go_wait) m_wait = 1;
      if (de) begin
        if (m_stock > 0) m_stock--;
        else m_err = 1;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    return {m_stock != 0, 6'(m_stock), m_wait, m_alarm, 4'(m_bottles), 7'(m_dozens), m_pulse, m_err};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {Rolha_Disponivel, Estoque, Req_Reposicao, Alarme_Reposicao, Garrafas, Duzias,
            Pulso_Duzia, Erro_Subfluxo};
  endfunction

  // One clock: drive at the falling edge, advance model at the rising edge,
  // return at the next falling edge ready to sample.
  task automatic cycle(input bit d, input bit i, input bit a, input bit r);
    Dec_Rolha = d; Inc_Duzia = i; Ack_Reposicao = a; Reset = r;
    @(posedge clk);
    model_step(d, i, a, r);
    @(negedge clk);
  endtask

  task automatic pulse_dec();
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
  endtask

  task automatic pulse_inc();
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== {1'b1, 6'd20, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0})
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), {1'b1, 6'd20, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_consume();
    for (int k = 0; k < 14; k++) pulse_dec();
    cycle(1, 0, 0, 1);
    n_checks++;
    if (Estoque !== 6'd5 || Req_Reposicao !== 1'b0)
      $display("FAIL consume_at5 got est=%0d req=%b exp est=5 req=0", Estoque, Req_Reposicao);
    else n_pass++;
    cycle(0, 0, 0, 1);
    n_checks++;
    if (Req_Reposicao !== 1'b1 || Rolha_Disponivel !== 1'b1 || Estoque !== 6'd5)
      $display("FAIL consume_req got req=%b disp=%b est=%0d exp req=1 disp=1 est=5",
               Req_Reposicao, Rolha_Disponivel, Estoque);
    else n_pass++;
  endtask

  task automatic test_refill();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 1);
      n_checks++;
      if (Estoque !== 6'd20 || Req_Reposicao !== 1'b0)
        $display("FAIL refill_hold%0d got est=%0d req=%b exp est=20 req=0", k, Estoque, Req_Reposicao);
      else n_pass++;
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    n_checks++;
    if (Estoque !== 6'd20 || Req_Reposicao !== 1'b0 || Alarme_Reposicao !== 1'b0)
      $display("FAIL refill_ack_in_normal got est=%0d req=%b alm=%b exp est=20 req=0 alm=0",
               Estoque, Req_Reposicao, Alarme_Reposicao);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL refill_model got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_underflow();
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 19; k++) pulse_dec();
    n_checks++;
    if (Estoque !== 6'd1 || Req_Reposicao !== 1'b1)
      $display("FAIL under_at1 got est=%0d req=%b exp est=1 req=1", Estoque, Req_Reposicao);
    else n_pass++;
    pulse_dec();
    n_checks++;
    if (Estoque !== 6'd0 || Rolha_Disponivel !== 1'b0 || Erro_Subfluxo !== 1'b0)
      $display("FAIL under_at0 got est=%0d disp=%b err=%b exp est=0 disp=0 err=0",
               Estoque, Rolha_Disponivel, Erro_Subfluxo);
    else n_pass++;
    pulse_dec();
    n_checks++;
    if (Estoque !== 6'd0 || Rolha_Disponivel !== 1'b0 || Erro_Subfluxo !== 1'b1)
      $display("FAIL under_err got est=%0d disp=%b err=%b exp est=0 disp=0 err=1",
               Estoque, Rolha_Disponivel, Erro_Subfluxo);
    else n_pass++;
    // SOLICITA was entered 30 cycles after reset; alarm lands TIMEOUT cycles later.
    for (int k = 0; k < TIMEOUT - 13; k++) cycle(0, 0, 0, 1);
    n_checks++;
    if (Alarme_Reposicao !== 1'b0) $display("FAIL alarm_early got=%b exp=0", Alarme_Reposicao);
    else n_pass++;
    cycle(0, 0, 0, 1);
    n_checks++;
    if (Alarme_Reposicao !== 1'b1 || Req_Reposicao !== 1'b1)
      $display("FAIL alarm_set got alm=%b req=%b exp alm=1 req=1", Alarme_Reposicao, Req_Reposicao);
    else n_pass++;
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
    n_checks++;
    if (Alarme_Reposicao !== 1'b1) $display("FAIL alarm_hold got=%b exp=1", Alarme_Reposicao);
    else n_pass++;
  endtask

  task automatic test_ack_dec();
    cycle(1, 0, 1, 1);
    n_checks++;
    if (Estoque !== 6'd19 || Alarme_Reposicao !== 1'b0 || Req_Reposicao !== 1'b0 || Erro_Subfluxo !== 1'b1)
      $display("FAIL ack_dec got est=%0d alm=%b req=%b err=%b exp est=19 alm=0 req=0 err=1",
               Estoque, Alarme_Reposicao, Req_Reposicao, Erro_Subfluxo);
    else n_pass++;
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 1);
    n_checks++;
    if (Estoque !== 6'd18 || Garrafas !== 4'd1)
      $display("FAIL both_edges got est=%0d garr=%0d exp est=18 garr=1", Estoque, Garrafas);
    else n_pass++;
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_dozen();
    cycle(0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 1, 0, 1);
      n_checks++;
      if (Garrafas !== 4'(k % 12) || Pulso_Duzia !== (k == 12))
        $display("FAIL dozen_step%0d got garr=%0d pulse=%b exp garr=%0d pulse=%b",
                 k, Garrafas, Pulso_Duzia, k % 12, k == 12);
      else n_pass++;
      cycle(0, 0, 0, 1);
      n_checks++;
      if (Pulso_Duzia !== 1'b0) $display("FAIL dozen_pulse_width%0d got=%b exp=0", k, Pulso_Duzia);
      else n_pass++;
    end
    n_checks++;
    if (Duzias !== 7'd1) $display("FAIL dozen_count got=%0d exp=1", Duzias);
    else n_pass++;
    for (int k = 0; k < 1176; k++) pulse_inc();
    n_checks++;
    if (Duzias !== 7'd99 || Garrafas !== 4'd0)
      $display("FAIL dozen_99 got duz=%0d garr=%0d exp duz=99 garr=0", Duzias, Garrafas);
    else n_pass++;
    for (int k = 0; k < 11; k++) pulse_inc();
    cycle(0, 1, 0, 1);
    n_checks++;
    if (Duzias !== 7'd0 || Garrafas !== 4'd0 || Pulso_Duzia !== 1'b1)
      $display("FAIL dozen_wrap got duz=%0d garr=%0d pulse=%b exp duz=0 garr=0 pulse=1",
               Duzias, Garrafas, Pulso_Duzia);
    else n_pass++;
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) pulse_inc();
    for (int k = 0; k < 15; k++) pulse_dec();
    cycle(0, 0, 0, 1);
    n_checks++;
    if (Req_Reposicao !== 1'b1 || Garrafas !== 4'd7)
      $display("FAIL midrst_pre got req=%b garr=%0d exp req=1 garr=7", Req_Reposicao, Garrafas);
    else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++;
    if (dut_vec() !== {1'b1, 6'd20, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0})
      $display("FAIL midrst_values got=%h exp=%h", dut_vec(), {1'b1, 6'd20, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_random();
    bit d, i, a, r;
    cycle(0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      d = ($urandom_range(0, 99) < 45);
      i = ($urandom_range(0, 99) < 45);
      a = ($urandom_range(0, 99) < 8);
      r = ($urandom_range(0, 399) != 0);
      cycle(d, i, a, r);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_consume();
    test_refill();
    test_underflow();
    test_ack_dec();
    test_back_to_back();
    test_dozen();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
